// File: rtl/depth_test_fb_writer.sv
// Depth-test framebuffer writer: owns the z-buffer, runs a read-compare-write
// depth test per pixel, and clears z-buffer/framebuffer between frames.
module depth_test_fb_writer #(
    parameter int                     FB_HRES     = 320,
    parameter int                     FB_VRES     = 180,
    parameter int                     ZW          = 21,
    parameter int                     COLOR_WIDTH = 16,
    parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = 16'h0000,
    parameter bit                     CLEAR_FB    = 1'b1,
    localparam int                    NPIX        = FB_HRES * FB_VRES,
    localparam int                    AW          = $clog2(NPIX),
    localparam int                    HW          = $clog2(FB_HRES),
    localparam int                    VW          = $clog2(FB_VRES)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   clear_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    input  logic [AW-1:0]          addr_in,
    input  logic [HW-1:0]          hcount_in,
    input  logic [VW-1:0]          vcount_in,
    input  logic [ZW-1:0]          z_in,
    input  logic [COLOR_WIDTH-1:0] color_in,
    input  logic                   last_pixel_in,
    input  logic                   last_tri_in,
    output logic                   fb_we_out,
    output logic [AW-1:0]          fb_addr_out,
    output logic [COLOR_WIDTH-1:0] fb_color_out,
    output logic                   frame_done_out,
    output logic                   busy_out,
    output logic [31:0]            pass_count_out,
    output logic [31:0]            reject_count_out
);

    typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    typedef struct packed {
        logic                   v;
        logic [AW-1:0]          addr;
        logic [ZW-1:0]          z;
        logic [COLOR_WIDTH-1:0] color;
    } pix_t;

    localparam logic [ZW-1:0] Z_FAR = {1'b0, {(ZW-1){1'b1}}};

    state_t                state;
    logic [AW-1:0]         clr_addr;
    pix_t                  s1, s2, s3;
    logic                  s3_pass;
    logic signed [ZW-1:0]  rd1, rd2;
    logic signed [ZW-1:0]  zmem [NPIX];

    logic                  hazard, accept, kill, s3_we;
    logic                  z_we;
    logic [AW-1:0]         z_waddr;
    logic [ZW-1:0]         z_wdata;
    logic                  unused_dbg;

    // Debug coordinates are carried by upstream but addr_in alone addresses memory.
    assign unused_dbg = ^{hcount_in, vcount_in};

    // Stalling on any in-flight match keeps read-after-write order without forwarding.
    assign hazard = (s1.v && s1.addr == addr_in) ||
                    (s2.v && s2.addr == addr_in) ||
                    (s3.v && s3.addr == addr_in);
    assign ready_out = (state == ST_RUN) && !hazard;
    assign accept    = valid_in && ready_out;
    assign kill      = clear_in && (state == ST_RUN || state == ST_DRAIN);
    assign s3_we     = s3.v && s3_pass && !kill;
    assign busy_out  = (state == ST_CLEAR) || (state == ST_DRAIN);

    assign z_we    = (state == ST_CLEAR) || s3_we;
    assign z_waddr = (state == ST_CLEAR) ? clr_addr : s3.addr;
    assign z_wdata = (state == ST_CLEAR) ? Z_FAR : s3.z;

    // NOTE: the z-buffer has no reset; the CLEAR sweep initialises it, which keeps it mappable to block RAM.
    always_ff @(posedge clk_in) begin
        if (z_we) zmem[z_waddr] <= z_wdata;
        rd1 <= zmem[addr_in];
        rd2 <= rd1;
    end

    // NOTE: rst_in gates this combinational decode so the write port is quiet during reset even though the reset state is CLEAR.
    always_comb begin
        fb_we_out    = 1'b0;
        fb_addr_out  = '0;
        fb_color_out = '0;
        if (rst_in) begin
            if (state == ST_CLEAR) begin
                fb_we_out    = CLEAR_FB;
                fb_addr_out  = clr_addr;
                fb_color_out = CLEAR_COLOR;
            end else if (s3_we) begin
                fb_we_out    = 1'b1;
                fb_addr_out  = s3.addr;
                fb_color_out = s3.color;
            end
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state            <= ST_CLEAR;
            clr_addr         <= '0;
            s1               <= '0;
            s2               <= '0;
            s3               <= '0;
            s3_pass          <= 1'b0;
            frame_done_out   <= 1'b0;
            pass_count_out   <= '0;
            reject_count_out <= '0;
        end else begin
            frame_done_out <= 1'b0;

            s1.v     <= accept && !clear_in;
            s1.addr  <= addr_in;
            s1.z     <= z_in;
            s1.color <= color_in;
            s2       <= s1;
            s2.v     <= s1.v && !clear_in;
            s3       <= s2;
            s3.v     <= s2.v && !clear_in;
            // Read data lines up with S2; the verdict is registered into S3.
            s3_pass  <= !s2.z[ZW-1] && (s2.z != '0) && ($signed(s2.z) < rd2);

            if (s3.v && !kill) begin
                if (s3_pass) begin
                    if (pass_count_out != '1) pass_count_out <= pass_count_out + 32'd1;
                end else begin
                    if (reject_count_out != '1) reject_count_out <= reject_count_out + 32'd1;
                end
            end

            case (state)
                ST_CLEAR: begin
                    if (clear_in) begin
                        clr_addr <= '0;
                    end else if (clr_addr == AW'(NPIX - 1)) begin
                        clr_addr         <= '0;
                        state            <= ST_RUN;
                        pass_count_out   <= '0;
                        reject_count_out <= '0;
                    end else begin
                        clr_addr <= clr_addr + AW'(1);
                    end
                end
                ST_RUN: begin
                    if (clear_in) begin
                        state    <= ST_CLEAR;
                        clr_addr <= '0;
                    end else if (accept && last_pixel_in && last_tri_in) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (clear_in) begin
                        state    <= ST_CLEAR;
                        clr_addr <= '0;
                    end else if (!s1.v) begin
                        // The final pixel now sits in S2 and writes next cycle, alongside the pulse.
                        frame_done_out <= 1'b1;
                        state          <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (clear_in) begin
                        state    <= ST_CLEAR;
                        clr_addr <= '0;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_depth_test_fb_writer.sv
// Randomised scoreboard bench for depth_test_fb_writer on a reduced 16x12
// framebuffer, with a behavioural z-buffer model and an independent fb-write monitor.
module tb_depth_test_fb_writer;

    localparam int HRES = 16;
    localparam int VRES = 12;
    localparam int NPIX = HRES * VRES;
    localparam int AW   = $clog2(NPIX);
    localparam int HW   = $clog2(HRES);
    localparam int VW   = $clog2(VRES);
    localparam int ZW   = 21;
    localparam int CW   = 16;
    localparam int ZMAX = (1 << (ZW - 1)) - 1;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          clear_in;
    logic          valid_in;
    logic          ready_out;
    logic [AW-1:0] addr_in;
    logic [HW-1:0] hcount_in;
    logic [VW-1:0] vcount_in;
    logic [ZW-1:0] z_in;
    logic [CW-1:0] color_in;
    logic          last_pixel_in;
    logic          last_tri_in;
    logic          fb_we_out;
    logic [AW-1:0] fb_addr_out;
    logic [CW-1:0] fb_color_out;
    logic          frame_done_out;
    logic          busy_out;
    logic [31:0]   pass_count_out;
    logic [31:0]   reject_count_out;

    depth_test_fb_writer #(
        .FB_HRES(HRES), .FB_VRES(VRES), .ZW(ZW), .COLOR_WIDTH(CW),
        .CLEAR_COLOR(16'h0000), .CLEAR_FB(1'b1)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .clear_in(clear_in),
        .valid_in(valid_in), .ready_out(ready_out), .addr_in(addr_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .z_in(z_in),
        .color_in(color_in), .last_pixel_in(last_pixel_in), .last_tri_in(last_tri_in),
        .fb_we_out(fb_we_out), .fb_addr_out(fb_addr_out), .fb_color_out(fb_color_out),
        .frame_done_out(frame_done_out), .busy_out(busy_out),
        .pass_count_out(pass_count_out), .reject_count_out(reject_count_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc++;

    typedef struct {
        int addr;
        int color;
        int cyc;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     failures = 0;
    int     done_pulses = 0;
    int     zref [NPIX];
    longint pass_m = 0;
    longint rej_m = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every framebuffer write must match the oldest expected write, including its cycle.
    exp_t e;
    always @(negedge clk_in) begin
        if (rst_in) begin
            if (frame_done_out) done_pulses++;
            if (fb_we_out) begin
                if (sb.size() == 0) begin
                    check("fb_we_unexpected", longint'(fb_we_out), 0);
                end else begin
                    e = sb.pop_front();
                    check("fb_addr", longint'(fb_addr_out), e.addr);
                    check("fb_color", longint'(fb_color_out), e.color);
                    check("fb_write_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // A clear rewrites every address with colour 0 on consecutive cycles and restores far depth.
    task automatic push_sweep(input int base);
        for (int k = 0; k < NPIX; k++) sb.push_back('{k, 0, base + k});
        for (int k = 0; k < NPIX; k++) zref[k] = ZMAX;
        pass_m = 0;
        rej_m  = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send(input int a, input int z, input int c, input bit last, input bit model,
                        output int t, output int stalls);
        addr_in       = AW'(a);
        hcount_in     = HW'(a % HRES);
        vcount_in     = VW'(a / HRES);
        z_in          = z[ZW-1:0];
        color_in      = c[CW-1:0];
        last_pixel_in = last;
        last_tri_in   = last;
        valid_in      = 1'b1;
        stalls = 0;
        t      = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_in);
            if (ready_out) begin
                t = cyc;
                break;
            end
            stalls++;
            @(posedge clk_in); #1;
        end
        if (t < 0) begin
            check("accept_timeout", longint'(ready_out), 1);
            @(posedge clk_in); #1;
        end else begin
            if (model) begin
                if (z > 0 && z < zref[a]) begin
                    zref[a] = z;
                    sb.push_back('{a, c, t + 3});
                    pass_m++;
                end else begin
                    rej_m++;
                end
            end
            @(posedge clk_in); #1;
        end
    endtask

    task automatic idle(input int n);
        valid_in      = 1'b0;
        last_pixel_in = 1'b0;
        last_tri_in   = 1'b0;
        repeat (n) begin
            @(posedge clk_in); #1;
        end
    endtask

    task automatic wait_sweep(output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < NPIX + 64; i++) begin
            @(negedge clk_in);
            if (!busy_out) break;
            busy_cycles++;
        end
        @(posedge clk_in); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, st, n, t_last, stall_sum, pulses, fd_cyc, bad_ready, base;
        rst_in = 1'b0; clear_in = 1'b0; valid_in = 1'b0;
        addr_in = '0; hcount_in = '0; vcount_in = '0; z_in = '0; color_in = '0;
        last_pixel_in = 1'b0; last_tri_in = 1'b0;

        repeat (3) @(posedge clk_in);
        #1;
        check("rst_ready", longint'(ready_out), 0);
        check("rst_fb_we", longint'(fb_we_out), 0);
        check("rst_busy", longint'(busy_out), 1);
        check("rst_frame_done", longint'(frame_done_out), 0);
        check("rst_fb_addr", longint'(fb_addr_out), 0);
        check("rst_fb_color", longint'(fb_color_out), 0);
        check("rst_pass_count", longint'(pass_count_out), 0);
        check("rst_reject_count", longint'(reject_count_out), 0);

        // Power-up sweep.
        rst_in = 1'b1;
        push_sweep(cyc);
        wait_sweep(n);
        check("sweep_busy_cycles", n, NPIX);
        check("sweep_writes_left", sb.size(), 0);
        check("ready_after_sweep", longint'(ready_out), 1);
        check("counters_after_sweep", longint'(pass_count_out) + longint'(reject_count_out), 0);

        // Single pixel, then a deeper pixel on the same address.
        send(5, 100, 16'hF800, 1'b0, 1'b1, t, st);
        send(5, 200, 16'h07E0, 1'b0, 1'b1, t, st);
        idle(6);
        check("single_pass_count", longint'(pass_count_out), pass_m);
        check("single_reject_count", longint'(reject_count_out), rej_m);

        // Same address back-to-back stalls until the first write lands.
        send(7, 300, 16'h001F, 1'b0, 1'b1, t, st);
        send(7, 50, 16'hFFE0, 1'b0, 1'b1, t, st);
        check("hazard_stall_cycles", st, 3);
        idle(6);
        check("hazard_pass_count", longint'(pass_count_out), pass_m);

        // Behind-camera and equal-depth rejects.
        send(30, 0, 16'h1111, 1'b0, 1'b1, t, st);
        send(40, -4, 16'h2222, 1'b0, 1'b1, t, st);
        send(7, 50, 16'h3333, 1'b0, 1'b1, t, st);
        idle(6);
        check("reject_count_after_rejects", longint'(reject_count_out), rej_m);
        check("writes_left_after_rejects", sb.size(), 0);

        // Random traffic over a small address window to provoke hazards.
        for (int i = 0; i < 80; i++) begin
            send(int'($urandom_range(0, 15)), int'($urandom_range(0, 1200)) - 200,
                 int'($urandom_range(0, 65535)), 1'b0, 1'b1, t, st);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(6);
        check("random_pass_count", longint'(pass_count_out), pass_m);
        check("random_reject_count", longint'(reject_count_out), rej_m);
        check("random_writes_left", sb.size(), 0);

        // Ten distinct addresses closing the frame.
        base = int'($urandom_range(16, NPIX - 11));
        stall_sum = 0;
        t_last = -1;
        for (int i = 0; i < 10; i++) begin
            send(base + i, int'($urandom_range(1, 5000)), int'($urandom_range(0, 65535)),
                 (i == 9), 1'b1, t, st);
            stall_sum += st;
            t_last = t;
        end
        valid_in = 1'b0; last_pixel_in = 1'b0; last_tri_in = 1'b0;
        pulses = 0; fd_cyc = -1; bad_ready = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_in);
            if (frame_done_out) begin
                pulses++;
                fd_cyc = cyc;
            end
            if (ready_out) bad_ready++;
        end
        @(posedge clk_in); #1;
        check("frame_stall_cycles", stall_sum, 0);
        check("frame_done_pulses_local", pulses, 1);
        check("frame_done_cycle", fd_cyc, t_last + 3);
        check("ready_high_after_last", bad_ready, 0);
        check("busy_in_done", longint'(busy_out), 0);
        check("frame_pass_count", longint'(pass_count_out), pass_m);
        check("frame_reject_count", longint'(reject_count_out), rej_m);
        check("frame_writes_left", sb.size(), 0);
        idle(5);
        check("done_ready_low", longint'(ready_out), 0);
        check("done_pass_hold", longint'(pass_count_out), pass_m);

        // Clear from DONE: sweep starts at address 0 on the next cycle.
        clear_in = 1'b1;
        push_sweep(cyc + 1);
        @(posedge clk_in); #1;
        clear_in = 1'b0;
        wait_sweep(n);
        check("clear_sweep_busy_cycles", n - 1, NPIX - 1);
        check("clear_sweep_writes_left", sb.size(), 0);
        check("clear_pass_zeroed", longint'(pass_count_out), 0);
        check("clear_reject_zeroed", longint'(reject_count_out), 0);

        // Mid-frame abort with two passing pixels in flight.
        send(20, 10, 16'h1234, 1'b0, 1'b0, t, st);
        send(21, 10, 16'h5678, 1'b0, 1'b0, t, st);
        valid_in = 1'b0;
        clear_in = 1'b1;
        push_sweep(cyc + 1);
        @(posedge clk_in); #1;
        clear_in = 1'b0;
        check("abort_busy", longint'(busy_out), 1);
        repeat (40) @(posedge clk_in);

        // Asynchronous reset in the middle of the sweep.
        #3;
        rst_in = 1'b0;
        #1;
        check("async_rst_fb_we", longint'(fb_we_out), 0);
        check("async_rst_fb_addr", longint'(fb_addr_out), 0);
        check("async_rst_ready", longint'(ready_out), 0);
        check("async_rst_busy", longint'(busy_out), 1);
        check("async_rst_pass_count", longint'(pass_count_out), 0);
        sb.delete();
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        push_sweep(cyc);
        wait_sweep(n);
        check("resweep_busy_cycles", n, NPIX);
        check("resweep_writes_left", sb.size(), 0);

        send(21, 77, 16'hABCD, 1'b0, 1'b1, t, st);
        idle(6);
        check("final_pass_count", longint'(pass_count_out), pass_m);
        check("final_writes_left", sb.size(), 0);
        check("total_frame_done_pulses", done_pulses, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
